// File: rtl/lc4_pkg.sv
// Shared LC4 definitions: control-flow opcodes, the OS entry PC and NZP bit positions.
package lc4_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [15:0] PC_RESET_DEFAULT = 16'h8200;

  // Bit positions inside the {N,Z,P} condition vector.
  localparam int unsigned NZP_N = 2;
  localparam int unsigned NZP_Z = 1;
  localparam int unsigned NZP_P = 0;

endpackage

// File: rtl/lc4_nzp_gen.sv
// Derives the one-hot {N,Z,P} condition code from a 16-bit two's-complement value.
module lc4_nzp_gen
  import lc4_pkg::*;
(
  input  logic [15:0] i_data,
  output logic [2:0]  o_nzp
);

  // Zero is tested first so that only the sign decides between N and P.
  always_comb begin
    o_nzp = 3'b000;
    if (i_data == 16'h0000) begin
      o_nzp[NZP_Z] = 1'b1;
    end else if (i_data[15]) begin
      o_nzp[NZP_N] = 1'b1;
    end else begin
      o_nzp[NZP_P] = 1'b1;
    end
  end

endmodule

// File: rtl/lc4_pc_unit.sv
// LC4 program counter, NZP condition register and PSR privilege bit, with the
// combinational next-PC selection for branches, jumps, TRAP and RTI.
module lc4_pc_unit
  import lc4_pkg::*;
#(
  parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic [15:0] i_insn,
  input  logic [15:0] i_alu_result,
  input  logic        i_nzp_we,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_pc,
  output logic [15:0] o_pc_plus_one,
  output logic [15:0] o_next_pc,
  output logic        o_branch_taken,
  output logic [2:0]  o_nzp,
  output logic        o_priv,
  output logic        o_priv_fault
);

  logic [15:0] r_pc;
  logic [2:0]  r_nzp;
  logic        r_priv;

  logic [3:0]  w_opcode;
  logic [2:0]  w_nzp_new;
  logic        w_redirect;
  logic        w_upd;
  logic        w_unused_insn;

  assign w_opcode      = i_insn[15:12];
  assign w_upd         = gwe & i_valid & ~i_stall;
  assign w_unused_insn = ^i_insn[8:0];

  lc4_nzp_gen u_nzp_gen (
    .i_data (i_wdata),
    .o_nzp  (w_nzp_new)
  );

  // Decode whether the instruction redirects the PC to the ALU target.
  always_comb begin
    w_redirect = 1'b0;
    case (w_opcode)
      OP_BR:   w_redirect = |(i_insn[11:9] & r_nzp);
      OP_JSR,
      OP_JMP,
      OP_RTI,
      OP_TRAP: w_redirect = 1'b1;
      default: w_redirect = 1'b0;
    endcase
  end

  // A bubble neither redirects nor advances: next PC is the current PC.
  always_comb begin
    o_branch_taken = 1'b0;
    o_next_pc      = o_pc_plus_one;
    if (!i_valid) begin
      o_branch_taken = 1'b0;
      o_next_pc      = r_pc;
    end else if (w_redirect) begin
      o_branch_taken = 1'b1;
      o_next_pc      = i_alu_result;
    end else begin
      o_branch_taken = 1'b0;
      o_next_pc      = o_pc_plus_one;
    end
  end

  // PC, NZP and PSR state; reset overrides any pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= PC_RESET;
      r_nzp  <= 3'b010;
      r_priv <= 1'b1;
    end else if (w_upd) begin
      r_pc <= o_next_pc;
      if (i_nzp_we) begin
        r_nzp <= w_nzp_new;
      end
      if (w_opcode == OP_TRAP) begin
        r_priv <= 1'b1;
      end else if (w_opcode == OP_RTI) begin
        r_priv <= 1'b0;
      end
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_plus_one = r_pc + 16'h0001;
  assign o_nzp         = r_nzp;
  assign o_priv        = r_priv;
  assign o_priv_fault  = r_pc[15] & ~r_priv;

endmodule

// File: tb/tb_lc4_pc_unit.sv
// Self-checking bench for lc4_pc_unit: directed scenarios followed by random
// instruction streams compared against an architectural model of PC/NZP/PSR.
module tb_lc4_pc_unit;

  logic        clk = 1'b0;
  logic        rst, gwe, i_valid, i_stall, i_nzp_we;
  logic [15:0] i_insn, i_alu_result, i_wdata;
  logic [15:0] o_pc, o_pc_plus_one, o_next_pc;
  logic        o_branch_taken, o_priv, o_priv_fault;
  logic [2:0]  o_nzp;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_pc;
  logic [2:0]  m_nzp;
  logic        m_priv;

  always #5 clk = ~clk;

  lc4_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .gwe            (gwe),
    .i_valid        (i_valid),
    .i_stall        (i_stall),
    .i_insn         (i_insn),
    .i_alu_result   (i_alu_result),
    .i_nzp_we       (i_nzp_we),
    .i_wdata        (i_wdata),
    .o_pc           (o_pc),
    .o_pc_plus_one  (o_pc_plus_one),
    .o_next_pc      (o_next_pc),
    .o_branch_taken (o_branch_taken),
    .o_nzp          (o_nzp),
    .o_priv         (o_priv),
    .o_priv_fault   (o_priv_fault)
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_nzp(input logic [15:0] d);
    if (d == 16'h0000) return 3'b010;
    if ($signed(d) < 0) return 3'b100;
    return 3'b001;
  endfunction

  function automatic bit ref_redirect(input logic [15:0] insn, input logic [2:0] nzp);
    logic [3:0] opc;
    opc = insn[15:12];
    if (opc inside {4'h4, 4'h8, 4'hC, 4'hF}) return 1'b1;
    if (opc == 4'h0) begin
      for (int i = 0; i < 3; i++) begin
        if (insn[9+i] && nzp[i]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check_regs(input string tag);
    check_val({tag, ".pc"},    o_pc, m_pc);
    check_val({tag, ".nzp"},   {13'h0, o_nzp}, {13'h0, m_nzp});
    check_val({tag, ".priv"},  {15'h0, o_priv}, {15'h0, m_priv});
    check_val({tag, ".fault"}, {15'h0, o_priv_fault}, {15'h0, m_pc[15] & ~m_priv});
  endtask

  // One cycle: drive at negedge, check combinational and state outputs, clock, advance model.
  task automatic step(input logic r, input logic g, input logic v, input logic s,
                      input logic [15:0] insn, input logic [15:0] alu,
                      input logic we, input logic [15:0] wd);
    logic        exp_taken;
    logic [15:0] exp_next;
    @(negedge clk);
    rst = r; gwe = g; i_valid = v; i_stall = s;
    i_insn = insn; i_alu_result = alu; i_nzp_we = we; i_wdata = wd;
    #1;
    exp_taken = v && ref_redirect(insn, m_nzp);
    exp_next  = !v ? m_pc : (exp_taken ? alu : 16'(m_pc + 16'd1));
    check_regs("state");
    check_val("pc_plus_one", o_pc_plus_one, 16'(m_pc + 16'd1));
    check_val("next_pc", o_next_pc, exp_next);
    check_val("taken", {15'h0, o_branch_taken}, {15'h0, exp_taken});
    @(posedge clk);
    if (r) begin
      m_pc = 16'h8200; m_nzp = 3'b010; m_priv = 1'b1;
    end else if (g && v && !s) begin
      m_pc = exp_next;
      if (we) m_nzp = ref_nzp(wd);
      if (insn[15:12] == 4'hF) m_priv = 1'b1;
      else if (insn[15:12] == 4'h8) m_priv = 1'b0;
    end
  endtask

  task automatic expect_state(input string tag, input logic [15:0] pc,
                              input logic [2:0] nzp, input logic priv, input logic fault);
    #2;
    check_val({tag, ".pc"},    o_pc, pc);
    check_val({tag, ".nzp"},   {13'h0, o_nzp}, {13'h0, nzp});
    check_val({tag, ".priv"},  {15'h0, o_priv}, {15'h0, priv});
    check_val({tag, ".fault"}, {15'h0, o_priv_fault}, {15'h0, fault});
  endtask

  initial begin
    logic [15:0] insn, alu, wd;
    logic [3:0]  opc_tab [8];
    opc_tab[0] = 4'h0; opc_tab[1] = 4'h0; opc_tab[2] = 4'h1; opc_tab[3] = 4'h4;
    opc_tab[4] = 4'h8; opc_tab[5] = 4'hC; opc_tab[6] = 4'hF; opc_tab[7] = 4'h5;

    rst = 1'b1; gwe = 1'b1; i_valid = 1'b0; i_stall = 1'b0;
    i_insn = 16'h0000; i_alu_result = 16'h0000; i_nzp_we = 1'b0; i_wdata = 16'h0000;
    @(posedge clk);
    m_pc = 16'h8200; m_nzp = 3'b010; m_priv = 1'b1;
    expect_state("reset", 16'h8200, 3'b010, 1'b1, 1'b0);

    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1, 16'hFFFE);
    expect_state("add_neg", 16'h8201, 3'b100, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0800, 16'h8300, 1'b0, 16'h0000);
    expect_state("brn_taken", 16'h8300, 3'b100, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1, 16'h0005);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0400, 16'h1234, 1'b0, 16'h0000);
    expect_state("brz_not_taken", 16'h8302, 3'b001, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h5555, 1'b0, 16'h0000);
    expect_state("br_nop", 16'h8303, 3'b001, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h0010, 1'b0, 16'h0000);
    expect_state("rti", 16'h0010, 3'b001, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hF025, 16'h80FF, 1'b1, 16'h0011);
    expect_state("trap", 16'h80FF, 3'b001, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000);
    expect_state("user_fault", 16'h8000, 3'b001, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'hC1C0, 16'h4444, 1'b1, 16'h0000);
    end
    expect_state("stall", 16'h8000, 3'b001, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hC1C0, 16'hFFFF, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, 16'h0000);
    expect_state("wrap", 16'h0000, 3'b001, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'hF0FF, 16'h1234, 1'b1, 16'h8000);
    expect_state("gwe_low", 16'h0000, 3'b001, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'hC1C0, 16'h4444, 1'b1, 16'hFFFF);
    expect_state("rst_in_stall", 16'h8200, 3'b010, 1'b1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      insn = 16'($urandom);
      insn[15:12] = opc_tab[$urandom_range(0, 7)];
      alu  = 16'($urandom);
      wd   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
           insn, alu, 1'($urandom), wd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lc4_pc_unit.md
# lc4_pc_unit

Program-counter and control-state stage of the single-cycle LC4 datapath. It holds the PC, the NZP condition register and the PSR privilege bit, and feeds `i_pc` to the execute ALU. It consumes the ALU's target result to decide the next PC for BR/JSR/JSRR/JMP/JMPR/TRAP/RTI. It updates NZP from the register-file write data.

## Interface
Parameters:
- `PC_RESET`, default 16'h8200: PC value after reset (OS entry).

Ports:
- `clk`  in  1  system clock. One clock domain; every register updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `gwe`  in  1  global write enable. When low, all state holds.
- `i_valid`  in  1  `i_insn` is a real instruction this cycle.
- `i_stall`  in  1  hold PC, NZP and PSR this cycle.
- `i_insn`  in  16  current instruction.
- `i_alu_result`  in  16  ALU output for `i_insn` (target address for control instructions).
- `i_nzp_we`  in  1  this instruction writes NZP.
- `i_wdata`  in  16  register-file write data, used to derive NZP.
- `o_pc`  out  16  current PC (registered).
- `o_pc_plus_one`  out  16  `o_pc + 1`, mod 2^16.
- `o_next_pc`  out  16  PC to be loaded at the next enabled edge.
- `o_branch_taken`  out  1  the current instruction redirects the PC.
- `o_nzp`  out  3  NZP register, ordered {N,Z,P}.
- `o_priv`  out  1  PSR[15]: 1 = OS mode.
- `o_priv_fault`  out  1  PC is in the OS region while in user mode.

## Operation
- Update condition `upd = gwe & i_valid & ~i_stall`. PC, NZP and PSR write only when `upd` is high.
- `o_next_pc` is combinational, decoded from `i_insn[15:12]`:
  - 0000 BR: taken when `(i_insn[11:9] & o_nzp) != 0`. If taken, next PC is `i_alu_result`; otherwise `o_pc_plus_one`. BR with `i_insn[11:9] = 000` is never taken (NOP).
  - 0100 JSR/JSRR, 1100 JMP/JMPR, 1000 RTI, 1111 TRAP: always taken; next PC is `i_alu_result`.
  - All other opcodes: next PC is `o_pc_plus_one`.
- `o_branch_taken` is 1 exactly when `o_next_pc` came from `i_alu_result`.
  - It is forced to 0 when `i_valid` is 0, and `o_next_pc` is then `o_pc`.
- NZP derivation from `i_wdata`:
  - N = `i_wdata[15]`.
  - Z = (`i_wdata == 0`).
  - P = otherwise.
  - Exactly one bit is set.
  - NZP loads when `upd & i_nzp_we`.
- PSR:
  - TRAP sets `o_priv` = 1 on `upd`.
  - RTI clears `o_priv` to 0 on `upd`.
  - No other opcode changes it.
- `o_priv_fault` = `o_pc[15] & ~o_priv`. It is combinational and does not block updates; the trap unit consumes it.
- All additions wrap modulo 2^16; 16'hFFFF + 1 = 16'h0000.

## Timing
- Reset values, applied on the first edge with `rst=1`:
  - PC = `PC_RESET`.
  - NZP = 3'b010 (Z).
  - `o_priv` = 1.
- Reset outputs: `o_branch_taken` = 0 while `i_valid`=0; `o_priv_fault` = 0.
- `rst` has priority over `gwe`, `i_stall` and `i_valid`. Reset asserted mid-instruction discards the pending update.
- Latency: `o_next_pc` and `o_branch_taken` are valid in the same cycle as `i_insn`. `o_pc` reflects them one edge later.
- BR evaluates the NZP value from before the edge. If the same instruction writes NZP, the new value is visible only to the next instruction.
- Stall: `i_stall=1` or `gwe=0` holds all three registers bit-exact, for any duration. `o_next_pc` still tracks inputs combinationally.
- TRAP and the NZP write (R7 <- PC+1) occur on the same edge; both take effect.

## Structure
- Shared package `lc4_pkg` contains:
  - opcode constants `OP_BR`, `OP_JSR`, `OP_RTI`, `OP_JMP`, `OP_TRAP`;
  - `PC_RESET_DEFAULT` = 16'h8200;
  - NZP bit indices.
- One sub-module: `lc4_nzp_gen` (combinational, 16-bit data in, 3-bit one-hot NZP out). It is reused by the writeback checker.
- Everything else is one always block for the registers plus combinational next-PC logic.

## Test plan
- Reset: assert `rst` for 1 cycle with `gwe=1` -> PC=16'h8200, NZP=3'b010, `o_priv`=1, `o_priv_fault`=0.
- Sequential flow: ADD with `i_nzp_we=1`, `i_wdata`=16'hFFFE -> PC 8200->8201, NZP=100. A following BRn with `i_alu_result`=16'h8300 -> `o_branch_taken`=1, PC=8300.
- Not-taken and NOP branch:
  - NZP=001, BRz with target 16'h1234 -> PC advances by 1.
  - BR with nzp field 000 -> PC advances by 1.
- Privilege:
  - RTI with `i_alu_result`=16'h0010 -> PC=0010, `o_priv`=0, `o_priv_fault`=0.
  - TRAP with `i_alu_result`=16'h80FF -> PC=80FF, `o_priv`=1.
  - Forcing PC to 8000 in user mode -> `o_priv_fault`=1.
- Stall/gwe/wrap:
  - `i_stall`=1 for 3 cycles under a taken JMP -> PC, NZP and PSR unchanged.
  - PC=FFFF with ADD -> PC=0000.
  - `gwe`=0 -> no update.
  - `rst` asserted mid-stall -> PC=8200.
